// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: runs one reconfiguration of the SDRAM clock PLL through
// the reconfig IP's Avalon-MM management port. The sequence is eight register
// writes, a PLL reset pulse, and then a wait for stable lock.
// A start that arrives while a run is in progress is queued and runs next.
// The queued request is the most recent one.
// Optional build macro: PLL_RECFG_RETRY_EN. When it is defined, the first lock
// timeout restarts the sequence once instead of pulsing o_error.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_start
// WR      | management write for r_step asserted, waiting for !waitrequest
// GAP     | idle spacing after an accepted write
// RST     | o_pll_reset held high
// LOCK    | waiting for LOCK_STABLE consecutive locked cycles or timeout

module pll_reconfig_seq #(
    parameter int GAP_CYCLES   = 7,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 5000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_cfg_m,
    input  logic [31:0] i_cfg_k,
    input  logic [31:0] i_cfg_c,
    output logic [5:0]  o_mgmt_address,
    output logic [31:0] o_mgmt_writedata,
    output logic        o_mgmt_write,
    input  logic        i_mgmt_waitrequest,
    input  logic        i_locked,
    output logic        o_pll_reset,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int RST_LOAD = (RST_CYCLES > 0) ? RST_CYCLES - 1 : 0;
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int STB_W    = $clog2(LOCK_STABLE + 1);
    localparam int TMO_W    = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_GAP,
        ST_RST,
        ST_LOCK
    } state_t;

    state_t             r_state;
    logic [2:0]         r_step;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [STB_W-1:0]   r_stab_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [31:0]        r_cfg_m, r_cfg_k, r_cfg_c;
    logic [31:0]        r_sh_m, r_sh_k, r_sh_c;
    logic               r_pend;
`ifdef PLL_RECFG_RETRY_EN
    logic               r_retried;
`endif

    logic               w_advance;
    logic               w_lock_ok;
    logic               w_tmo;
    logic               w_retry;
    logic               w_take_new;
    logic [31:0]        w_new_m, w_new_k, w_new_c;
    logic [37:0]        w_nxt_entry;

    // Fixed write list: {address, data} for a given step
    function automatic logic [37:0] wr_entry(input logic [2:0] step,
                                             input logic [31:0] m,
                                             input logic [31:0] k,
                                             input logic [31:0] c);
        logic [37:0] e;
        e = '0;
        case (step)
            3'd0: e = {6'd0, 32'd0};
            3'd1: e = {6'd4, m};
            3'd2: e = {6'd7, k};
            3'd3: e = {6'd3, 32'h0001_0000};
            3'd4: e = {6'd5, c};
            3'd5: e = {6'd9, 32'd1};
            3'd6: e = {6'd8, 32'd7};
            3'd7: e = {6'd2, 32'd0};
            default: e = '0;
        endcase
        return e;
    endfunction

    // Step advance, lock/timeout decisions, and selection of the next request
    always_comb begin
        w_advance   = ((r_state == ST_WR) && !i_mgmt_waitrequest && (GAP_CYCLES == 0)) ||
                      ((r_state == ST_GAP) && (r_gap_cnt == '0));
        w_lock_ok   = i_locked && (r_stab_cnt == STB_W'(LOCK_STABLE - 1));
        w_tmo       = !w_lock_ok && (r_tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));
        // An incoming start on the final cycle beats the older shadow set.
        w_take_new  = i_start || r_pend;
        w_new_m     = i_start ? i_cfg_m : r_sh_m;
        w_new_k     = i_start ? i_cfg_k : r_sh_k;
        w_new_c     = i_start ? i_cfg_c : r_sh_c;
        w_nxt_entry = wr_entry(r_step + 3'd1, r_cfg_m, r_cfg_k, r_cfg_c);
`ifdef PLL_RECFG_RETRY_EN
        // A queued request takes priority over retrying the failed one.
        w_retry     = w_tmo && !w_take_new && !r_retried;
`else
        w_retry     = 1'b0;
`endif
    end

    // Sequencer FSM with registered management, reset and status outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= ST_IDLE;
            r_step           <= '0;
            r_gap_cnt        <= '0;
            r_rst_cnt        <= '0;
            r_stab_cnt       <= '0;
            r_tmo_cnt        <= '0;
            r_cfg_m          <= '0;
            r_cfg_k          <= '0;
            r_cfg_c          <= '0;
            r_sh_m           <= '0;
            r_sh_k           <= '0;
            r_sh_c           <= '0;
            r_pend           <= 1'b0;
`ifdef PLL_RECFG_RETRY_EN
            r_retried        <= 1'b0;
`endif
            o_mgmt_address   <= '0;
            o_mgmt_writedata <= '0;
            o_mgmt_write     <= 1'b0;
            o_pll_reset      <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_error          <= 1'b0;
        end else begin
            o_done  <= 1'b0;
            o_error <= 1'b0;

            if (i_start && (r_state != ST_IDLE)) begin
                r_pend <= 1'b1;
                r_sh_m <= i_cfg_m;
                r_sh_k <= i_cfg_k;
                r_sh_c <= i_cfg_c;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cfg_m          <= i_cfg_m;
                        r_cfg_k          <= i_cfg_k;
                        r_cfg_c          <= i_cfg_c;
`ifdef PLL_RECFG_RETRY_EN
                        r_retried        <= 1'b0;
`endif
                        r_step           <= '0;
                        o_mgmt_address   <= '0;
                        o_mgmt_writedata <= '0;
                        o_mgmt_write     <= 1'b1;
                        o_busy           <= 1'b1;
                        r_state          <= ST_WR;
                    end
                end

                ST_WR: begin
                    if (!i_mgmt_waitrequest && (GAP_CYCLES > 0)) begin
                        o_mgmt_write <= 1'b0;
                        r_gap_cnt    <= GAP_W'(GAP_LOAD);
                        r_state      <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end

                ST_RST: begin
                    if (r_rst_cnt == '0) begin
                        o_pll_reset <= 1'b0;
                        r_stab_cnt  <= '0;
                        r_tmo_cnt   <= '0;
                        r_state     <= ST_LOCK;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - 1'b1;
                    end
                end

                ST_LOCK: begin
                    if (!i_locked) begin
                        r_stab_cnt <= '0;
                    end else if (r_stab_cnt != STB_W'(LOCK_STABLE)) begin
                        r_stab_cnt <= r_stab_cnt + 1'b1;
                    end
                    if (r_tmo_cnt != TMO_W'(LOCK_TIMEOUT)) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end

                    if (w_lock_ok) begin
                        o_done <= 1'b1;
                    end else if (w_tmo && !w_retry) begin
                        o_error <= 1'b1;
                    end

                    if (w_lock_ok || w_tmo) begin
                        if (w_retry || w_take_new) begin
                            if (!w_retry) begin
                                r_cfg_m   <= w_new_m;
                                r_cfg_k   <= w_new_k;
                                r_cfg_c   <= w_new_c;
                                r_pend    <= 1'b0;
                            end
`ifdef PLL_RECFG_RETRY_EN
                            r_retried <= w_retry;
`endif
                            r_step           <= '0;
                            o_mgmt_address   <= '0;
                            o_mgmt_writedata <= '0;
                            o_mgmt_write     <= 1'b1;
                            r_state          <= ST_WR;
                        end else begin
                            o_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase

            if (w_advance) begin
                if (r_step == 3'd7) begin
                    o_mgmt_write <= 1'b0;
                    o_pll_reset  <= 1'b1;
                    r_rst_cnt    <= RST_W'(RST_LOAD);
                    r_state      <= ST_RST;
                end else begin
                    r_step                              <= r_step + 3'd1;
                    {o_mgmt_address, o_mgmt_writedata}  <= w_nxt_entry;
                    o_mgmt_write                        <= 1'b1;
                    r_state                             <= ST_WR;
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: table of runs plus reset corner cases.
module tb_pll_reconfig_seq;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset, start, wait_r, locked;
    logic [31:0] cfg_m, cfg_k, cfg_c;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        wr, pll_rst, busy, done, err;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    pll_reconfig_seq #(
        .GAP_CYCLES   (7),
        .RST_CYCLES   (8),
        .LOCK_STABLE  (16),
        .LOCK_TIMEOUT (TMO)
    ) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_start            (start),
        .i_cfg_m            (cfg_m),
        .i_cfg_k            (cfg_k),
        .i_cfg_c            (cfg_c),
        .o_mgmt_address     (addr),
        .o_mgmt_writedata   (wdata),
        .o_mgmt_write       (wr),
        .i_mgmt_waitrequest (wait_r),
        .i_locked           (locked),
        .o_pll_reset        (pll_rst),
        .o_busy             (busy),
        .o_done             (done),
        .o_error            (err)
    );

    typedef struct {
        logic [31:0] m, k, c;
        int          stall_len;
        int          glitch_at;
        int          lock_never;
        int          p1_n, p2_n;
        logic [31:0] p1_m, p2_m;
        int          exp_done, exp_err, exp_end;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] exp_entry(input int i, input logic [31:0] m,
                                              input logic [31:0] k, input logic [31:0] c);
        case (i)
            0: return {6'd0, 32'd0};
            1: return {6'd4, m};
            2: return {6'd7, k};
            3: return {6'd3, 32'h10000};
            4: return {6'd5, c};
            5: return {6'd9, 32'd1};
            6: return {6'd8, 32'd7};
            default: return {6'd2, 32'd0};
        endcase
    endfunction

    function automatic vec_t mk(input logic [31:0] m, k, c, input int stall, glitch, never,
                                input int p1n, input logic [31:0] p1m, input int p2n,
                                input logic [31:0] p2m, input int ed, ee, eend);
        vec_t v;
        v.m = m; v.k = k; v.c = c;
        v.stall_len = stall; v.glitch_at = glitch; v.lock_never = never;
        v.p1_n = p1n; v.p1_m = p1m; v.p2_n = p2n; v.p2_m = p2m;
        v.exp_done = ed; v.exp_err = ee; v.exp_end = eend;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [37:0] exp_q[$];
        logic [37:0] got_q[$];
        int  rst_hi = 0, dn = 0, er = 0, end_n = 0, stall_left = 0, k_cyc = 0;
        int  busy_low = 0, fall_n = 0, tail = 0, target, n;
        bit  stall_used = 0, prev_rst = 0, seen_rst = 0, fin = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_entry(i, v.m, v.k, v.c));
        if (v.p2_n > 0)
            for (int i = 0; i < 8; i++) exp_q.push_back(exp_entry(i, v.p2_m, v.k, v.c));
        else if (v.p1_n > 0)
            for (int i = 0; i < 8; i++) exp_q.push_back(exp_entry(i, v.p1_m, v.k, v.c));
`ifdef PLL_RECFG_RETRY_EN
        if (v.lock_never != 0)
            for (int i = 0; i < 8; i++) exp_q.push_back(exp_entry(i, v.m, v.k, v.c));
`endif
        target = v.exp_done + v.exp_err;

        @(negedge clk);
        cfg_m = v.m; cfg_k = v.k; cfg_c = v.c;
        start = 1'b1; wait_r = 1'b0; locked = (v.lock_never == 0);
        for (n = 1; n < 600; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin dn++; end_n = n; end
            if (err)  begin er++; end_n = n; end
            if (!busy && (dn + er) < target) busy_low++;
            if (pll_rst) begin rst_hi++; seen_rst = 1; end
            if (!pll_rst && prev_rst && fall_n == 0) fall_n = n;
            prev_rst = pll_rst;
            if (wr && addr == 6'd7 && v.stall_len > 0 && !stall_used) begin
                stall_used = 1; stall_left = v.stall_len;
            end
            if (stall_left > 0) begin wait_r = 1'b1; stall_left--; end
            else wait_r = 1'b0;
            if (wr && !wait_r) got_q.push_back({addr, wdata});
            if (wr && addr == 6'd7 && wdata == v.k && !seen_rst) k_cyc++;
            locked = (v.lock_never == 0) &&
                     !(v.glitch_at > 0 && fall_n > 0 && n == fall_n + v.glitch_at);
            if (n == v.p1_n) begin start = 1'b1; cfg_m = v.p1_m; end
            if (n == v.p2_n) begin start = 1'b1; cfg_m = v.p2_m; end
            if ((dn + er) >= target && tail == 0) tail = n;
            if (tail != 0 && n >= tail + 3) begin fin = 1; break; end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL %s_budget: run did not finish within 600 cycles (done=%0d error=%0d)", tag, dn, er);
        end
        chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_rst_hi"}, rst_hi, 8 * (exp_q.size() / 8));
        chk({tag, "_done_cnt"}, dn, v.exp_done);
        chk({tag, "_err_cnt"}, er, v.exp_err);
        chk({tag, "_end_cycle"}, end_n, v.exp_end);
        chk({tag, "_k_hold"}, k_cyc, 1 + v.stall_len);
        chk({tag, "_busy_gap"}, busy_low, 0);
        chk({tag, "_busy_end"}, busy, 0);
        wait_r = 1'b0; locked = 1'b1; start = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        int   k;
        bit   hit;
        reset = 1'b1; start = 1'b0; wait_r = 1'b0; locked = 1'b1;
        cfg_m = '0; cfg_k = '0; cfg_c = '0;
        repeat (3) @(negedge clk);
        chk("rst_addr", addr, 0);
        chk("rst_data", wdata, 0);
        chk("rst_write", wr, 0);
        chk("rst_pll_reset", pll_rst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", err, 0);
        reset = 1'b0;

        vecs[0] = mk(32'h167, 32'h808, 32'h20302, 0, 0, 0, 0, 0, 0, 0, 1, 0, 89);
        vecs[1] = mk(32'h167, 32'h808, 32'h20302, 5, 0, 0, 0, 0, 0, 0, 1, 0, 94);
        vecs[2] = mk(32'h1A, 32'h0, 32'h10101, 0, 10, 0, 0, 0, 0, 0, 1, 0, 100);
`ifdef PLL_RECFG_RETRY_EN
        vecs[3] = mk(32'h2C, 32'h12345, 32'h404, 0, 0, 1, 0, 0, 0, 0, 0, 1, 225);
`else
        vecs[3] = mk(32'h2C, 32'h12345, 32'h404, 0, 0, 1, 0, 0, 0, 0, 0, 1, 73 + TMO);
`endif
        vecs[4] = mk(32'h167, 32'h808, 32'h20302, 0, 0, 0, 20, 32'h55, 30, 32'h90, 2, 0, 177);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Reset while the PLL reset pulse is active
        @(negedge clk);
        cfg_m = 32'h77; cfg_k = 32'h1; cfg_c = 32'h2; start = 1'b1;
        hit = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (pll_rst) begin hit = 1; break; end
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL midrst_reach: pll_reset never rose within 200 cycles");
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_pll_reset", pll_rst, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_write", wr, 0);
        k = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || err || busy) k++;
        end
        chk("midrst_quiet", k, 0);
        run_vec(vecs[0], 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Sequences one reconfiguration of the SDRAM clock PLL through the Avalon-MM management port of the PLL reconfig IP.
- Flow: mode write, M/K/N/C0/charge-pump/bandwidth writes, apply, PLL reset pulse, then wait for stable lock.
- Replaces the free-running step counter in the memtest top level.
- Runs on the 50 MHz management clock. The frequency table and key handling stay outside; this block only consumes one latched {M, K, C0} set per request.

Parameters:
- GAP_CYCLES, 7, idle cycles inserted after each accepted management write (0 allowed).
- RST_CYCLES, 8, cycles pll_reset is held high.
- LOCK_STABLE, 16, consecutive cycles locked must be high before done.
- LOCK_TIMEOUT, 5000000, cycles allowed after reset release to reach stable lock (100 ms at 50 MHz).

Ports:
- clk  in  1  50 MHz management clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request; cfg_* sampled on the same cycle.
- cfg_m  in  32  M counter word (register 4).
- cfg_k  in  32  fractional K word (register 7).
- cfg_c  in  32  C0 counter word (register 5).
- mgmt_address  out  6  reconfig address.
- mgmt_writedata  out  32  reconfig write data.
- mgmt_write  out  1  write strobe.
- mgmt_waitrequest  in  1  Avalon wait.
- locked  in  1  PLL lock (already synchronised to clk).
- pll_reset  out  1  PLL reset.
- busy  out  1  high from the cycle after an accepted start until done/error.
- done  out  1  one-cycle pulse on successful lock.
- error  out  1  one-cycle pulse on lock timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; pending flag clear.
- Reset mid-operation: the sequence is abandoned immediately. pll_reset, mgmt_write, busy and pending go low on the next edge; no done/error pulse.
- IDLE:
  - On start, latch cfg_* and go to WR with step=0; busy=1 the next cycle.
  - locked is not required to start.
- WR, fixed write list by step (address, data):
  - 0: (0, 0)
  - 1: (4, cfg_m)
  - 2: (7, cfg_k)
  - 3: (3, 0x10000)
  - 4: (5, cfg_c)
  - 5: (9, 1)
  - 6: (8, 7)
  - 7: (2, 0)
- Write handshake:
  - mgmt_write rises with address and data valid in the same cycle.
  - mgmt_write, address and data are held stable while mgmt_waitrequest=1.
  - The write is accepted on the first edge with mgmt_write=1 and mgmt_waitrequest=0; mgmt_write drops the next cycle.
  - There is no timeout on waitrequest.
- GAP: count GAP_CYCLES idle cycles (skipped if 0). Then:
  - step<7: step+1, back to WR.
  - step==7: go to RST.
- RST: pll_reset=1 for exactly RST_CYCLES cycles, then 0; go to LOCK.
- LOCK:
  - A stable counter increments while locked=1 and clears on any locked=0.
  - When it reaches LOCK_STABLE: done pulse, busy=0, go to IDLE.
  - A timeout counter starts at pll_reset fall. If it reaches LOCK_TIMEOUT first: error pulse, busy=0, go to IDLE.
- Minimum total latency, start to done, with waitrequest=0 and locked immediate:
  - 8 writes × (1 + GAP_CYCLES) + RST_CYCLES + LOCK_STABLE + 1 cycles.
  - With default parameters this is 89 cycles.
- start while busy:
  - Sets pending and overwrites a shadow cfg set (last request wins).
  - In the cycle the current run would return to IDLE, done/error still pulses. The block then re-enters WR step 0 with the shadow set, and busy stays high continuously.
- start coincident with done/error: treated as pending.
- Counters saturate; they never wrap. Timeout counter width is ceil(log2(LOCK_TIMEOUT+1)).

Optional Feature:
- PLL_RECFG_RETRY_EN:
  - Defined: on lock timeout, restart the full sequence (WR step 0, same latched cfg) once, with no error pulse. error pulses only if the retry also times out. A pending request pre-empts the retry and is taken instead.
  - Undefined: the first timeout pulses error and returns to IDLE.

Test Plan:
- Basic run: start with cfg_m=0x167, cfg_k=0x808, cfg_c=0x20302, waitrequest=0, locked=1 -> exactly 8 writes (0:0, 4:0x167, 7:0x808, 3:0x10000, 5:0x20302, 9:1, 8:7, 2:0), pll_reset high 8 cycles, done 89 cycles after start.
- Waitrequest stall: hold waitrequest=1 for 5 cycles on the K write -> address 7 and data 0x808 stable for 6 cycles, one write accepted, done delayed by exactly 5 cycles.
- Lock glitch: locked drops for 1 cycle at stable count 10 -> count restarts; done at 16 consecutive high cycles.
- Timeout: locked=0 permanently -> error pulse LOCK_TIMEOUT cycles after pll_reset falls, no done, busy low. With PLL_RECFG_RETRY_EN: second write sequence observed, error after the second timeout.
- Pending: two starts during a run, second with cfg_m=0x90 -> first run done, then one further run using 0x90; busy never drops between runs.
- Reset mid-RST state -> pll_reset=0 and busy=0 on the next cycle; a later start runs normally.
